wm_cycle_sequencer: RTL and testbench
=====================================

# wm_cycle_sequencer

Wash-program sequencer for the washing-machine controller. Steps a fixed FILL → WASH → DRAIN → RINSE → SPIN programme using per-phase down-counters, and drives valve and motor enables. It sits directly upstream of the 8-bit datapath stage: its `ctrl`/`data_out` pair feeds that stage's `ctrl`/`data_in` every cycle. It also handles door-open pause, cancel-with-drain and fill-timeout error.

## Interface
- `FILL_MAX`, 8'd200: fill timeout in cycles (1..255).
- `WASH_T`, 8'd100: normal wash duration in cycles (1..255).
- `DRAIN_T`, 8'd40: drain duration in cycles (1..255).
- `RINSE_T`, 8'd60: rinse duration in cycles (1..255).
- `SPIN_T`, 8'd50: spin duration in cycles (1..255).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low (asserted when 0).
- `start` in 1: programme start request, sampled in IDLE only.
- `mode` in 2: programme select, sampled with `start`: 00 normal, 01 quick, 10 heavy, 11 spin-only.
- `door_closed` in 1: 1 = door locked shut.
- `water_full` in 1: level sensor, 1 = drum full.
- `cancel` in 1: abort request.
- `ctrl` out 3: op code to downstream datapath.
- `data_out` out 8: current phase timer value, to downstream `data_in`.
- `fill_valve` out 1: inlet valve enable.
- `drain_valve` out 1: drain pump enable.
- `motor` out 1: drum motor enable.
- `state` out 3: current state encoding.
- `busy` out 1: 1 in any state other than IDLE, DONE and ERROR.
- `paused` out 1: door-open pause active.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: fill timeout latched.

## Operation
- States and encoding: IDLE=0, FILL=1, WASH=2, DRAIN=3, RINSE=4, SPIN=5, DONE=6, ERROR=7.
- Registered elements:
  - `state`: 3-bit register.
  - `timer`: 8-bit down-counter.
  - `mode_r`: 2-bit register.
  - `abort_r`: 1-bit flag.
  - `paused`: register.
- Output decode:
  - All outputs except `paused` decode from registered state and timer only. There is no combinational path from inputs to outputs.
  - `data_out` = `timer`.
- Phase entry:
  - Entering a timed phase loads `timer` with duration−1.
  - The phase ends on the cycle where `timer`==0, so each phase lasts exactly `duration` cycles.
  - FILL loads `FILL_MAX`−1 as a timeout.
- Wash duration per `mode_r`:
  - 00 (normal): `WASH_T`.
  - 01 (quick): `WASH_T`>>1, minimum 1.
  - 10 (heavy): 2×`WASH_T`, saturating at 255.
- Transitions:
  - IDLE → FILL when `start`&`door_closed`. If `mode`==11, IDLE → DRAIN instead. `start` with the door open is ignored.
  - FILL → WASH when `water_full`, which is checked before the timeout. FILL → ERROR when `timer`==0 and !`water_full`.
  - WASH → DRAIN at `timer`==0.
  - DRAIN at `timer`==0:
    - If `abort_r`: → IDLE and clear `abort_r`.
    - Else if `mode_r`==11: → SPIN.
    - Else: → RINSE.
  - RINSE → SPIN at `timer`==0.
  - SPIN → DONE at `timer`==0.
  - DONE → IDLE unconditionally after 1 cycle.
  - ERROR → IDLE only on `cancel`.
- Output decode per state:
  - FILL: `ctrl`=010, `fill_valve`=1.
  - WASH: `ctrl`=001, `motor`=1.
  - RINSE: `ctrl`=001, `fill_valve`=1, `motor`=1.
  - SPIN: `ctrl`=011, `motor`=1, `drain_valve`=1.
  - DRAIN: `ctrl`=000, `drain_valve`=1.
  - IDLE, DONE, ERROR: `ctrl`=000, all enables 0.
- Pause:
  - Triggered when !`door_closed` in FILL, WASH, RINSE or SPIN.
  - Effects: `paused`=1, `timer` holds, state holds; `fill_valve`, `motor` and `drain_valve` are forced to 0 and `ctrl`=000.
  - Pause releases the cycle after `door_closed` returns.
  - DRAIN is never paused.
- Cancel:
  - In FILL, WASH, RINSE or SPIN, paused or not: → DRAIN, load `DRAIN_T`−1, set `abort_r`.
  - In DRAIN: sets `abort_r`; timer continues.
  - Ignored in IDLE and DONE.
  - Priority, highest first: cancel > pause > normal transition.
- `error` is 1 while in ERROR. `done` is 1 only in DONE.

## Timing
- Reset (`rst`=0):
  - `state`=IDLE, `timer`=0, `mode_r`=0, `abort_r`=0, `paused`=0.
  - Hence `ctrl`=000, `data_out`=0, all enables, `busy`, `done` and `error` = 0.
  - Takes effect immediately and asynchronously.
- Reset mid-programme: all valves and the motor drop at once, and the programme is lost.
- Latency: `start` sampled at edge N gives `state`=FILL after edge N, with `fill_valve`=1 in cycle N+1.
- `water_full` high before edge M gives WASH after edge M.
- `timer` decrements by 1 per unpaused cycle within a phase. It never wraps below 0, because the phase exits at 0.
- `start` during a busy programme is ignored. `mode` is sampled only at programme start.

## Test plan
- Full normal programme. Setup: `FILL_MAX`=20, `WASH_T`=4, `DRAIN_T`=3, `RINSE_T`=3, `SPIN_T`=2; `start` at cycle 0, `water_full` at cycle 5. Required:
  - FILL 1–5, WASH 6–9 with `data_out` 3,2,1,0, DRAIN 10–12, RINSE 13–15, SPIN 16–17, DONE 18, IDLE 19.
  - `done`=1 only in cycle 18.
  - `ctrl` sequence 010, 001, 000, 001, 011.
- Fill timeout: `water_full` held 0 with `FILL_MAX`=20 → ERROR after 20 FILL cycles, `error`=1, `fill_valve`=0. Then `cancel` → IDLE.
- Door pause: open the door in WASH at `timer`=2 for 5 cycles → `paused`=1, `motor`=0, `ctrl`=000, `data_out` holds 2. On door close, WASH resumes and exits 3 cycles later.
- Cancel mid-RINSE → DRAIN for `DRAIN_T` cycles with `drain_valve`=1, then IDLE with no `done` pulse.
- Modes:
  - `mode`=11 → IDLE→DRAIN→SPIN→DONE, and FILL is never entered.
  - `mode`=10 with `WASH_T`=200 → WASH lasts 255 cycles.
  - `mode`=01 with `WASH_T`=1 → WASH lasts 1 cycle.
- Reset mid-SPIN (`rst`=0 asynchronously, between clock edges) → `motor`, `drain_valve` and `ctrl` go 0 without waiting for a clock edge, `state`=0. `start` is ignored while `door_closed`=0.

Source files
------------

// File: rtl/wm_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// wm_cycle_sequencer
//   Wash-programme sequencer: FILL -> WASH -> DRAIN -> RINSE -> SPIN -> DONE,
//   timed by one shared 8-bit down-counter that is reloaded on phase entry.
//   Handles door-open pause, cancel-with-drain and fill timeout (ERROR).
//
// Parameters (cycles, 1..255):
//   FILL_MAX  fill timeout        WASH_T   normal wash duration
//   DRAIN_T   drain duration      RINSE_T  rinse duration
//   SPIN_T    spin duration
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active low
//   start        in   programme start, sampled in IDLE only
//   mode[1:0]    in   00 normal, 01 quick, 10 heavy, 11 spin-only
//   door_closed  in   1 = door locked shut
//   water_full   in   drum level sensor
//   cancel       in   abort request
//   ctrl[2:0]    out  op code to downstream datapath
//   data_out[7:0]out  current phase timer
//   fill_valve   out  inlet valve enable
//   drain_valve  out  drain pump enable
//   motor        out  drum motor enable
//   state[2:0]   out  current FSM state (debug/observation)
//   busy         out  active programme (not IDLE/DONE/ERROR)
//   paused       out  door-open pause active
//   done         out  one-cycle completion pulse
//   error        out  fill timeout
//
// All outputs are decoded from registers only; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module wm_cycle_sequencer #(
  parameter logic [7:0] FILL_MAX = 8'd200,
  parameter logic [7:0] WASH_T   = 8'd100,
  parameter logic [7:0] DRAIN_T  = 8'd40,
  parameter logic [7:0] RINSE_T  = 8'd60,
  parameter logic [7:0] SPIN_T   = 8'd50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       door_closed,
  input  logic       water_full,
  input  logic       cancel,
  output logic [2:0] ctrl,
  output logic [7:0] data_out,
  output logic       fill_valve,
  output logic       drain_valve,
  output logic       motor,
  output logic [2:0] state,
  output logic       busy,
  output logic       paused,
  output logic       done,
  output logic       error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_WASH  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_RINSE = 3'd4;
  localparam logic [2:0] S_SPIN  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERROR = 3'd7;

  // Wash duration variants, resolved at elaboration time.
  localparam logic [7:0] WASH_HALF  = WASH_T >> 1;
  localparam logic [7:0] WASH_QUICK = (WASH_HALF == 8'd0) ? 8'd1 : WASH_HALF;
  localparam logic [8:0] WASH_DBL   = {WASH_T, 1'b0};
  localparam logic [7:0] WASH_HEAVY = WASH_DBL[8] ? 8'hFF : WASH_DBL[7:0];

  logic [2:0] r_state;
  logic [7:0] r_timer;
  logic [1:0] r_mode;
  logic       r_abort;
  logic       r_paused;

  logic [2:0] w_state_nxt;
  logic [7:0] w_timer_nxt;
  logic [1:0] w_mode_nxt;
  logic       w_abort_nxt;
  logic       w_paused_nxt;
  logic [7:0] w_wash_load;

  always_comb begin
    case (r_mode)
      2'b01:   w_wash_load = WASH_QUICK - 8'd1;
      2'b10:   w_wash_load = WASH_HEAVY - 8'd1;
      default: w_wash_load = WASH_T - 8'd1;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_mode_nxt   = r_mode;
    w_abort_nxt  = r_abort;
    w_paused_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && door_closed) begin
          w_mode_nxt = mode;
          if (mode == 2'b11) begin
            w_state_nxt = S_DRAIN;
            w_timer_nxt = DRAIN_T - 8'd1;
          end else begin
            w_state_nxt = S_FILL;
            w_timer_nxt = FILL_MAX - 8'd1;
          end
        end
      end
      S_FILL, S_WASH, S_RINSE, S_SPIN: begin
        if (cancel) begin
          // Cancel beats pause: always drain the drum before returning idle.
          w_state_nxt = S_DRAIN;
          w_timer_nxt = DRAIN_T - 8'd1;
          w_abort_nxt = 1'b1;
        end else if (!door_closed) begin
          // Hold state and timer while the door is open.
          w_paused_nxt = 1'b1;
        end else begin
          case (r_state)
            S_FILL: begin
              // Level sensor wins over the timeout on the same cycle.
              if (water_full) begin
                w_state_nxt = S_WASH;
                w_timer_nxt = w_wash_load;
              end else if (r_timer == 8'd0) begin
                w_state_nxt = S_ERROR;
              end else begin
                w_timer_nxt = r_timer - 8'd1;
              end
            end
            S_WASH: begin
              if (r_timer == 8'd0) begin
                w_state_nxt = S_DRAIN;
                w_timer_nxt = DRAIN_T - 8'd1;
              end else begin
                w_timer_nxt = r_timer - 8'd1;
              end
            end
            S_RINSE: begin
              if (r_timer == 8'd0) begin
                w_state_nxt = S_SPIN;
                w_timer_nxt = SPIN_T - 8'd1;
              end else begin
                w_timer_nxt = r_timer - 8'd1;
              end
            end
            default: begin // S_SPIN
              if (r_timer == 8'd0) begin
                w_state_nxt = S_DONE;
              end else begin
                w_timer_nxt = r_timer - 8'd1;
              end
            end
          endcase
        end
      end
      S_DRAIN: begin
        if (cancel) begin
          w_abort_nxt = 1'b1;
        end
        if (r_timer == 8'd0) begin
          // A cancel arriving on the final drain cycle still aborts.
          if (r_abort || cancel) begin
            w_state_nxt = S_IDLE;
            w_abort_nxt = 1'b0;
          end else if (r_mode == 2'b11) begin
            w_state_nxt = S_SPIN;
            w_timer_nxt = SPIN_T - 8'd1;
          end else begin
            w_state_nxt = S_RINSE;
            w_timer_nxt = RINSE_T - 8'd1;
          end
        end else begin
          w_timer_nxt = r_timer - 8'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin // S_ERROR
        if (cancel) begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_timer  <= 8'd0;
      r_mode   <= 2'b00;
      r_abort  <= 1'b0;
      r_paused <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_mode   <= w_mode_nxt;
      r_abort  <= w_abort_nxt;
      r_paused <= w_paused_nxt;
    end
  end

  always_comb begin
    ctrl        = 3'b000;
    fill_valve  = 1'b0;
    drain_valve = 1'b0;
    motor       = 1'b0;
    case (r_state)
      S_FILL: begin
        ctrl       = 3'b010;
        fill_valve = 1'b1;
      end
      S_WASH: begin
        ctrl  = 3'b001;
        motor = 1'b1;
      end
      S_RINSE: begin
        ctrl       = 3'b001;
        fill_valve = 1'b1;
        motor      = 1'b1;
      end
      S_SPIN: begin
        ctrl        = 3'b011;
        motor       = 1'b1;
        drain_valve = 1'b1;
      end
      S_DRAIN: begin
        drain_valve = 1'b1;
      end
      default: begin
      end
    endcase
    // Door open: everything that moves water or the drum is switched off.
    if (r_paused) begin
      ctrl        = 3'b000;
      fill_valve  = 1'b0;
      drain_valve = 1'b0;
      motor       = 1'b0;
    end
  end

  assign data_out = r_timer;
  assign state    = r_state;
  assign paused   = r_paused;
  assign busy     = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
  assign done     = (r_state == S_DONE);
  assign error    = (r_state == S_ERROR);

endmodule

// File: tb/tb_wm_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wm_cycle_sequencer
//   Self-checking bench. Main DUT uses short phase timings; two extra
//   instances (WASH_T=200 and WASH_T=1) share its inputs for wash-mode
//   duration checks.
// -----------------------------------------------------------------------------
module tb_wm_cycle_sequencer;

  localparam int W = 21;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_WASH  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_RINSE = 3'd4;
  localparam logic [2:0] S_SPIN  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERROR = 3'd7;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       start;
  logic [1:0] mode;
  logic       door_closed;
  logic       water_full;
  logic       cancel;

  logic [2:0] ctrl;
  logic [7:0] data_out;
  logic       fill_valve, drain_valve, motor, busy, paused, done, error;
  logic [2:0] state;

  logic [2:0] h_ctrl, h_state;
  logic [7:0] h_data;
  logic       h_fv, h_dv, h_mo, h_busy, h_paused, h_done, h_error;

  logic [2:0] q_ctrl, q_state;
  logic [7:0] q_data;
  logic       q_fv, q_dv, q_mo, q_busy, q_paused, q_done, q_error;

  wm_cycle_sequencer #(
    .FILL_MAX(8'd20), .WASH_T(8'd4), .DRAIN_T(8'd3), .RINSE_T(8'd3), .SPIN_T(8'd2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .door_closed(door_closed),
    .water_full(water_full), .cancel(cancel), .ctrl(ctrl), .data_out(data_out),
    .fill_valve(fill_valve), .drain_valve(drain_valve), .motor(motor),
    .state(state), .busy(busy), .paused(paused), .done(done), .error(error)
  );

  wm_cycle_sequencer #(
    .FILL_MAX(8'd20), .WASH_T(8'd200), .DRAIN_T(8'd3), .RINSE_T(8'd3), .SPIN_T(8'd2)
  ) dut_h (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .door_closed(door_closed),
    .water_full(water_full), .cancel(cancel), .ctrl(h_ctrl), .data_out(h_data),
    .fill_valve(h_fv), .drain_valve(h_dv), .motor(h_mo),
    .state(h_state), .busy(h_busy), .paused(h_paused), .done(h_done), .error(h_error)
  );

  wm_cycle_sequencer #(
    .FILL_MAX(8'd20), .WASH_T(8'd1), .DRAIN_T(8'd3), .RINSE_T(8'd3), .SPIN_T(8'd2)
  ) dut_q (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .door_closed(door_closed),
    .water_full(water_full), .cancel(cancel), .ctrl(q_ctrl), .data_out(q_data),
    .fill_valve(q_fv), .drain_valve(q_dv), .motor(q_mo),
    .state(q_state), .busy(q_busy), .paused(q_paused), .done(q_done), .error(q_error)
  );

  logic [W-1:0] obs;
  assign obs = {state, ctrl, fill_valve, drain_valve, motor, busy, done, error, paused, data_out};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int    n_tests;
  int    n_fail;
  string cur_tag;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  // Expected observable vector for a state/timer/pause combination,
  // from the output decode table.
  function automatic logic [W-1:0] pack_exp(input logic [2:0] st, input logic [7:0] tmr,
                                            input logic p);
    logic [2:0] c;
    logic fv, dv, mo, bz;
    c = 3'b000; fv = 1'b0; dv = 1'b0; mo = 1'b0;
    case (st)
      S_FILL:  begin c = 3'b010; fv = 1'b1; end
      S_WASH:  begin c = 3'b001; mo = 1'b1; end
      S_RINSE: begin c = 3'b001; fv = 1'b1; mo = 1'b1; end
      S_SPIN:  begin c = 3'b011; mo = 1'b1; dv = 1'b1; end
      S_DRAIN: begin dv = 1'b1; end
      default: begin end
    endcase
    if (p) begin
      c = 3'b000; fv = 1'b0; dv = 1'b0; mo = 1'b0;
    end
    bz = (st >= S_FILL) && (st <= S_SPIN);
    return {st, c, fv, dv, mo, bz, st == S_DONE, st == S_ERROR, p, tmr};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) check_eq(cur_tag, obs, exp_q.pop_front());
  endtask

  task automatic exp_tick(input logic [2:0] st, input logic [7:0] tmr, input logic p = 1'b0);
    exp_q.push_back(pack_exp(st, tmr, p));
    tick();
  endtask

  task automatic run_phase(input logic [2:0] st, input int dur);
    for (int t = dur - 1; t >= 0; t--) exp_tick(st, 8'(t));
  endtask

  task automatic count_wash(input logic [1:0] m, output int n_m, output int n_h, output int n_q);
    n_m = 0; n_h = 0; n_q = 0;
    mode = m; start = 1'b1; water_full = 1'b1;
    repeat (300) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (state == S_WASH) n_m++;
      if (h_state == S_WASH) n_h++;
      if (q_state == S_WASH) n_q++;
    end
    water_full = 1'b0;
    mode = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int nm, nh, nq;
    n_tests = 0; n_fail = 0;
    rst = 1'b0; start = 1'b0; mode = 2'b00; door_closed = 1'b1;
    water_full = 1'b0; cancel = 1'b0;
    cur_tag = "reset";
    #2;
    check_eq("reset_state", obs, pack_exp(S_IDLE, 8'd0, 1'b0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Full normal programme
    cur_tag = "normal";
    start = 1'b1;
    exp_tick(S_FILL, 8'd19);
    start = 1'b0;
    for (int t = 18; t >= 15; t--) exp_tick(S_FILL, 8'(t));
    water_full = 1'b1;
    run_phase(S_WASH, 4);
    water_full = 1'b0;
    run_phase(S_DRAIN, 3);
    run_phase(S_RINSE, 3);
    run_phase(S_SPIN, 2);
    exp_tick(S_DONE, 8'd0);
    exp_tick(S_IDLE, 8'd0);
    exp_tick(S_IDLE, 8'd0);

    // Fill timeout
    cur_tag = "fill_timeout";
    start = 1'b1;
    exp_tick(S_FILL, 8'd19);
    start = 1'b0;
    for (int t = 18; t >= 0; t--) exp_tick(S_FILL, 8'(t));
    exp_tick(S_ERROR, 8'd0);
    exp_tick(S_ERROR, 8'd0);
    cancel = 1'b1;
    exp_tick(S_IDLE, 8'd0);
    cancel = 1'b0;

    // Door pause in WASH at timer=2
    cur_tag = "pause";
    start = 1'b1;
    exp_tick(S_FILL, 8'd19);
    start = 1'b0;
    water_full = 1'b1;
    exp_tick(S_WASH, 8'd3);
    water_full = 1'b0;
    exp_tick(S_WASH, 8'd2);
    door_closed = 1'b0;
    repeat (5) exp_tick(S_WASH, 8'd2, 1'b1);
    door_closed = 1'b1;
    exp_tick(S_WASH, 8'd1);
    exp_tick(S_WASH, 8'd0);
    run_phase(S_DRAIN, 3);
    run_phase(S_RINSE, 3);
    run_phase(S_SPIN, 2);
    exp_tick(S_DONE, 8'd0);
    exp_tick(S_IDLE, 8'd0);

    // Cancel mid-RINSE
    cur_tag = "cancel_rinse";
    start = 1'b1;
    exp_tick(S_FILL, 8'd19);
    start = 1'b0;
    water_full = 1'b1;
    run_phase(S_WASH, 4);
    water_full = 1'b0;
    run_phase(S_DRAIN, 3);
    exp_tick(S_RINSE, 8'd2);
    cancel = 1'b1;
    exp_tick(S_DRAIN, 8'd2);
    cancel = 1'b0;
    exp_tick(S_DRAIN, 8'd1);
    exp_tick(S_DRAIN, 8'd0);
    exp_tick(S_IDLE, 8'd0);
    exp_tick(S_IDLE, 8'd0);

    // Spin-only mode
    cur_tag = "spin_only";
    mode = 2'b11; start = 1'b1;
    exp_tick(S_DRAIN, 8'd2);
    start = 1'b0; mode = 2'b00;
    exp_tick(S_DRAIN, 8'd1);
    exp_tick(S_DRAIN, 8'd0);
    run_phase(S_SPIN, 2);
    exp_tick(S_DONE, 8'd0);
    exp_tick(S_IDLE, 8'd0);

    // Wash length per mode
    count_wash(2'b10, nm, nh, nq);
    check_eq("heavy_wash_t4",   W'(nm), W'(8));
    check_eq("heavy_wash_t200", W'(nh), W'(255));
    check_eq("heavy_wash_t1",   W'(nq), W'(2));
    count_wash(2'b01, nm, nh, nq);
    check_eq("quick_wash_t4",   W'(nm), W'(2));
    check_eq("quick_wash_t200", W'(nh), W'(100));
    check_eq("quick_wash_t1",   W'(nq), W'(1));
    count_wash(2'b00, nm, nh, nq);
    check_eq("normal_wash_t200", W'(nh), W'(200));

    // Async reset mid-SPIN, then start ignored with door open
    cur_tag = "reset_spin";
    mode = 2'b11; start = 1'b1;
    exp_tick(S_DRAIN, 8'd2);
    start = 1'b0; mode = 2'b00;
    exp_tick(S_DRAIN, 8'd1);
    exp_tick(S_DRAIN, 8'd0);
    exp_tick(S_SPIN, 8'd1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_reset", obs, pack_exp(S_IDLE, 8'd0, 1'b0));
    door_closed = 1'b0;
    start = 1'b1;
    #2;
    rst = 1'b1;
    cur_tag = "start_door_open";
    exp_tick(S_IDLE, 8'd0);
    exp_tick(S_IDLE, 8'd0);
    start = 1'b0;
    door_closed = 1'b1;

    if (exp_q.size() != 0) check_eq("queue_drained", W'(exp_q.size()), W'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
